// File: rtl/iobuf_ctrl_pkg.sv
// Shared types and arbitration helper for the bidirectional buffer direction controller.
// Latency: n/a (types and a pure function).
// Backpressure: n/a.
package iobuf_ctrl_pkg;

    localparam int CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DRIVE_A = 2'd1,
        DRIVE_B = 2'd2,
        TURN    = 2'd3
    } state_e;

    typedef enum logic {
        SIDE_A = 1'b0,
        SIDE_B = 1'b1
    } side_e;

    // Round-robin pick used both from IDLE and at the end of a turnaround.
    function automatic state_e arb_pick(input logic ra, input logic rb, input side_e ptr);
        state_e pick;
        pick = IDLE;
        if (ra && rb) begin
            if (ptr == SIDE_A) pick = DRIVE_A;
            else               pick = DRIVE_B;
        end else if (ra) begin
            pick = DRIVE_A;
        end else if (rb) begin
            pick = DRIVE_B;
        end
        return pick;
    endfunction

endpackage

// File: rtl/iobuf_turn_timer.sv
// Loadable down-counter that times the dead cycles between bus owners.
// Latency: zero flag reflects the registered count; load takes effect next cycle.
// Backpressure: none; saturates at zero while dec stays asserted.
module iobuf_turn_timer
    import iobuf_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/iobuf_dir_ctrl.sv
// Round-robin direction controller for a shared A/B tristate buffer pair with dead-time turnaround.
// Latency: grant one edge after the request is sampled; release one edge after req drops.
// Backpressure: losing side waits; owner is preempted after MAX_HOLD contended cycles.
module iobuf_dir_ctrl
    import iobuf_ctrl_pkg::*;
#(
    parameter int TURN_CYCLES = 2,
    parameter int MAX_HOLD    = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req_a,
    input  logic req_b,
    output logic gnt_a,
    output logic gnt_b,
    output logic oe_a,
    output logic oe_b,
    output logic dir,
    output logic busy
);

    localparam logic [CNT_W-1:0] TURN_LOAD = CNT_W'(TURN_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);
    localparam logic             HOLD_EN   = (MAX_HOLD != 0);

    state_e           state, state_nxt;
    side_e            ptr;
    logic [CNT_W-1:0] hold_cnt;
    logic             other_req;
    logic             in_drive;
    logic             preempt;
    logic             turn_load;
    logic             turn_zero;

    assign in_drive  = (state == DRIVE_A) || (state == DRIVE_B);
    assign other_req = (state == DRIVE_A) ? req_b : req_a;
    // hold_cnt counts contended edges already seen; this edge would make it MAX_HOLD.
    assign preempt   = HOLD_EN && in_drive && other_req && (hold_cnt == HOLD_LAST);

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    state_nxt = arb_pick(req_a, req_b, ptr);
            DRIVE_A: if (!req_a || preempt) state_nxt = TURN;
            DRIVE_B: if (!req_b || preempt) state_nxt = TURN;
            TURN:    if (turn_zero) state_nxt = arb_pick(req_a, req_b, ptr);
            default: state_nxt = IDLE;
        endcase
    end

    assign turn_load = (state_nxt == TURN) && (state != TURN);

    iobuf_turn_timer u_turn_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (turn_load),
        .load_val (TURN_LOAD),
        .dec      (state == TURN),
        .zero     (turn_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ptr      <= SIDE_A;
            dir      <= 1'b0;
            hold_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state_nxt == DRIVE_A) begin
                dir <= 1'b1;
                ptr <= SIDE_B;
            end else if (state_nxt == DRIVE_B) begin
                dir <= 1'b0;
                ptr <= SIDE_A;
            end
            if (in_drive && (state_nxt == state) && other_req) begin
                if (hold_cnt != '1) hold_cnt <= hold_cnt + 1'b1;
            end else begin
                hold_cnt <= '0;
            end
        end
    end

    assign gnt_a = (state == DRIVE_A);
    assign gnt_b = (state == DRIVE_B);
    assign oe_a  = gnt_a;
    assign oe_b  = gnt_b;
    assign busy  = (state != IDLE);

endmodule

// File: tb/tb_iobuf_dir_ctrl.sv
// Directed and random checks of iobuf_dir_ctrl: two instances (TURN 2 and TURN 3, MAX_HOLD 4).
// Expected per-cycle outputs are queued as stimulus is driven and popped when sampled.
module tb_iobuf_dir_ctrl;

    localparam int TC0 = 2;
    localparam int TC1 = 3;
    localparam int MH  = 4;

    typedef logic [5:0] exp_t;  // {gnt_a, gnt_b, oe_a, oe_b, dir, busy}

    logic clk = 1'b0;
    logic rst_n;
    logic ra0, rb0, ga0, gb0, oa0, ob0, dr0, bz0;
    logic ra1, rb1, ga1, gb1, oa1, ob1, dr1, bz1;

    int   tests = 0;
    int   fails = 0;
    exp_t sbq[$];
    int   gap[2];
    int   wait_a[2];
    int   wait_b[2];
    logic prev_any[2];

    always #5 clk = ~clk;

    iobuf_dir_ctrl #(.TURN_CYCLES(TC0), .MAX_HOLD(MH)) u0 (
        .clk(clk), .rst_n(rst_n), .req_a(ra0), .req_b(rb0),
        .gnt_a(ga0), .gnt_b(gb0), .oe_a(oa0), .oe_b(ob0), .dir(dr0), .busy(bz0)
    );

    iobuf_dir_ctrl #(.TURN_CYCLES(TC1), .MAX_HOLD(MH)) u1 (
        .clk(clk), .rst_n(rst_n), .req_a(ra1), .req_b(rb1),
        .gnt_a(ga1), .gnt_b(gb1), .oe_a(oa1), .oe_b(ob1), .dir(dr1), .busy(bz1)
    );

    function automatic exp_t obs(input int sel);
        if (sel == 0) return {ga0, gb0, oa0, ob0, dr0, bz0};
        return {ga1, gb1, oa1, ob1, dr1, bz1};
    endfunction

    task automatic chk(input string tag, input logic [7:0] o, input logic [7:0] e);
        tests++;
        assert (o === e) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, o, e);
        end
    endtask

    // Drive one cycle of requests, queue the outputs expected after the next edge, then compare.
    task automatic step(input int sel, input logic a, input logic b,
                        input logic e_ga, input logic e_gb, input logic e_dir, input logic e_busy,
                        input string tag);
        @(negedge clk);
        if (sel == 0) begin ra0 = a; rb0 = b; end
        else          begin ra1 = a; rb1 = b; end
        sbq.push_back({e_ga, e_gb, e_ga, e_gb, e_dir, e_busy});
        @(posedge clk);
        #1;
        chk(tag, 8'(obs(sel)), 8'(sbq.pop_front()));
    endtask

    task automatic rchk(input int sel, input int tc, input logic ra, input logic rb);
        exp_t o;
        o = obs(sel);
        chk("no_overlap", 8'(o[3] & o[2]), 8'd0);
        chk("oe_eq_gnt", 8'(o[3:2]), 8'(o[5:4]));
        if (o[3] | o[2]) begin
            if (!prev_any[sel]) chk("dead_gap", 8'(gap[sel] >= tc), 8'd1);
            gap[sel] = 0;
        end else if (gap[sel] < 10000) begin
            gap[sel]++;
        end
        prev_any[sel] = o[3] | o[2];
        // A side preempted while still requesting sees its own turnaround, the other's hold, then another turnaround.
        if (ra && !o[5]) wait_a[sel]++; else wait_a[sel] = 0;
        if (rb && !o[4]) wait_b[sel]++; else wait_b[sel] = 0;
        chk("starve_a", 8'(wait_a[sel] <= MH + 2 * tc + 1), 8'd1);
        chk("starve_b", 8'(wait_b[sel] <= MH + 2 * tc + 1), 8'd1);
    endtask

    initial begin
        rst_n = 1'b0;
        ra0 = 1'b0; rb0 = 1'b0; ra1 = 1'b0; rb1 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_u0", 8'(obs(0)), 8'd0);
        chk("reset_u1", 8'(obs(1)), 8'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single A transfer, TURN 2.
        step(0, 1, 0, 1, 0, 1, 1, "a_grant");
        for (int i = 1; i < 5; i++) step(0, 1, 0, 1, 0, 1, 1, "a_hold");
        step(0, 0, 0, 0, 0, 1, 1, "a_rel_turn0");
        step(0, 0, 0, 0, 0, 1, 1, "a_rel_turn1");
        step(0, 0, 0, 0, 0, 1, 0, "a_idle");

        // Asynchronous reset in the middle of DRIVE_A.
        step(0, 1, 0, 1, 0, 1, 1, "rst_pre");
        #2 rst_n = 1'b0;
        #1 chk("rst_async", 8'(obs(0)), 8'd0);
        @(negedge clk);
        ra0 = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step(0, 0, 0, 0, 0, 0, 0, "rst_idle");

        // Simultaneous request after reset: pointer favours A.
        for (int i = 0; i < 3; i++) step(0, 1, 1, 1, 0, 1, 1, "sim_a");
        step(0, 0, 1, 0, 0, 1, 1, "sim_turn0");
        step(0, 0, 1, 0, 0, 1, 1, "sim_turn1");
        step(0, 0, 1, 0, 1, 0, 1, "sim_b");
        step(0, 0, 0, 0, 0, 0, 1, "sim_bturn0");
        step(0, 0, 0, 0, 0, 0, 1, "sim_bturn1");
        step(0, 0, 0, 0, 0, 0, 0, "sim_idle");

        // Preemption of A after MAX_HOLD contended cycles.
        for (int i = 0; i < 10; i++) step(0, 1, 0, 1, 0, 1, 1, "pre_a");
        for (int i = 10; i < 13; i++) step(0, 1, 1, 1, 0, 1, 1, "pre_hold");
        step(0, 1, 1, 0, 0, 1, 1, "pre_cut");
        step(0, 1, 1, 0, 0, 1, 1, "pre_turn");
        step(0, 1, 1, 0, 1, 0, 1, "pre_b");
        step(0, 1, 1, 0, 1, 0, 1, "pre_b_hold");
        step(0, 1, 1, 0, 1, 0, 1, "pre_b_hold");
        step(0, 1, 0, 0, 0, 0, 1, "pre_brel0");
        step(0, 1, 0, 0, 0, 0, 1, "pre_brel1");
        step(0, 1, 0, 1, 0, 1, 1, "pre_regrant_a");
        step(0, 0, 0, 0, 0, 1, 1, "pre_arel0");
        step(0, 0, 0, 0, 0, 1, 1, "pre_arel1");
        step(0, 0, 0, 0, 0, 1, 0, "pre_idle");

        // Request withdrawn during TURN ends in IDLE.
        step(0, 1, 0, 1, 0, 1, 1, "wd_a");
        step(0, 0, 1, 0, 0, 1, 1, "wd_turn0");
        step(0, 0, 0, 0, 0, 1, 1, "wd_turn1");
        step(0, 0, 0, 0, 0, 1, 0, "wd_idle");

        // Same-side re-grant, TURN 3.
        step(1, 1, 0, 1, 0, 1, 1, "rg_a");
        step(1, 0, 0, 0, 0, 1, 1, "rg_drop");
        step(1, 1, 0, 0, 0, 1, 1, "rg_turn1");
        step(1, 1, 0, 0, 0, 1, 1, "rg_turn2");
        step(1, 1, 0, 1, 0, 1, 1, "rg_regrant");
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 1, 1, "rg_rel_turn");
        step(1, 0, 0, 0, 0, 1, 0, "rg_idle");

        chk("sbq_empty", 8'(sbq.size()), 8'd0);

        // Random request streams on both instances.
        for (int s = 0; s < 2; s++) begin
            gap[s] = 10000; wait_a[s] = 0; wait_b[s] = 0; prev_any[s] = 1'b0;
        end
        for (int c = 0; c < 10000; c++) begin
            @(negedge clk);
            if ($urandom_range(0, 7) == 0) ra0 = ~ra0;
            if ($urandom_range(0, 7) == 0) rb0 = ~rb0;
            if ($urandom_range(0, 5) == 0) ra1 = ~ra1;
            if ($urandom_range(0, 5) == 0) rb1 = ~rb1;
            @(posedge clk);
            #1;
            rchk(0, TC0, ra0, rb0);
            rchk(1, TC1, ra1, rb1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
